// File: rtl/rf_tx_underrun_guard.sv
// rf_tx_underrun_guard
// Output conditioner between the 2-to-4 up-sampler and the DAC interface.
// It presents a continuous 4 SPC stream. When upstream valid drops while
// streaming, it substitutes zeros. It stays muted until the input has been
// valid for HOLDOFF_CYCLES consecutive cycles. It also keeps underrun stats.
//
// Ports:
//   clk             sample clock; all logic runs on it
//   rst             asynchronous active-high reset
//   enable          stream enable (level)
//   clear_stats     one-cycle pulse that clears underrun_count / underrun_sticky
//   i_tdata         4 SPC input; sample n = i_tdata[n*32 +: 32] = {Q, I}
//   i_tvalid        input qualifier (no backpressure possible)
//   o_tdata         conditioned samples, same packing as i_tdata
//   o_tvalid        high in every state except IDLE
//   underrun_count  saturating underrun event count
//   underrun_sticky set by any underrun event
//   state           debug state: IDLE=0, ARM=1, RUN=2, HOLD=3
module rf_tx_underrun_guard #(
    parameter int HOLDOFF_CYCLES = 8,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear_stats,
    input  logic [127:0]     i_tdata,
    input  logic             i_tvalid,
    output logic [127:0]     o_tdata,
    output logic             o_tvalid,
    output logic [CNT_W-1:0] underrun_count,
    output logic             underrun_sticky,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // The last discarded valid beat of the holdoff window has this count.
    localparam logic [15:0]      HOLDOFF_LAST = 16'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t             state_reg, state_next;
    logic [15:0]        holdoff_cnt_reg, holdoff_cnt_next;
    logic [127:0]       o_tdata_reg, o_tdata_next;
    logic               o_tvalid_reg, o_tvalid_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               sticky_reg, sticky_next;
    logic               underrun_event;

    // State and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            holdoff_cnt_reg <= '0;
            o_tdata_reg     <= '0;
            o_tvalid_reg    <= 1'b0;
            count_reg       <= '0;
            sticky_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            holdoff_cnt_reg <= holdoff_cnt_next;
            o_tdata_reg     <= o_tdata_next;
            o_tvalid_reg    <= o_tvalid_next;
            count_reg       <= count_next;
            sticky_reg      <= sticky_next;
        end
    end

    // Next-state logic, including the holdoff counter.
    always_comb begin
        state_next       = state_reg;
        holdoff_cnt_next = holdoff_cnt_reg;
        underrun_event   = 1'b0;
        if (!enable) begin
            state_next       = ST_IDLE;
            holdoff_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_ARM;
                ST_ARM: begin
                    if (i_tvalid) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!i_tvalid) begin
                        state_next       = ST_HOLD;
                        holdoff_cnt_next = '0;
                        underrun_event   = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_tvalid) begin
                        // This valid beat is discarded. If it completes the
                        // window, passthrough starts on the next valid beat.
                        if (holdoff_cnt_reg == HOLDOFF_LAST) begin
                            state_next       = ST_RUN;
                            holdoff_cnt_next = '0;
                        end else begin
                            holdoff_cnt_next = holdoff_cnt_reg + 16'd1;
                        end
                    end else begin
                        // A gap restarts the window. It is not a new event.
                        holdoff_cnt_next = '0;
                    end
                end
                default: begin
                    state_next       = ST_IDLE;
                    holdoff_cnt_next = '0;
                end
            endcase
        end
    end

    // Output and stats logic. The results are registered above.
    always_comb begin
        o_tvalid_next = (state_next != ST_IDLE);
        o_tdata_next  = '0;
        if (enable && i_tvalid && (state_reg == ST_ARM || state_reg == ST_RUN)) begin
            o_tdata_next = i_tdata;
        end

        count_next  = count_reg;
        sticky_next = sticky_reg;
        // Clear is applied first, so a coincident event leaves count=1.
        if (clear_stats) begin
            count_next  = '0;
            sticky_next = 1'b0;
        end
        if (underrun_event) begin
            sticky_next = 1'b1;
            if (count_next != CNT_MAX) begin
                count_next = count_next + 1'b1;
            end
        end
    end

    assign o_tdata         = o_tdata_reg;
    assign o_tvalid        = o_tvalid_reg;
    assign underrun_count  = count_reg;
    assign underrun_sticky = sticky_reg;
    assign state           = state_reg;

endmodule

// File: tb/tb_rf_tx_underrun_guard.sv
// Testbench for rf_tx_underrun_guard (HOLDOFF_CYCLES=8, CNT_W=4).
// A table of input and expected-output records is applied one per clock.
// The expected result of each record is queued when it is driven. It is
// popped and compared one clock later. Reset and async reset are checked
// by hand-written sequences.
module tb_rf_tx_underrun_guard;

    localparam int HOLD = 8;
    localparam int CW   = 4;

    logic           clk;
    logic           rst;
    logic           enable;
    logic           clear_stats;
    logic [127:0]   i_tdata;
    logic           i_tvalid;
    logic [127:0]   o_tdata;
    logic           o_tvalid;
    logic [CW-1:0]  underrun_count;
    logic           underrun_sticky;
    logic [1:0]     state;

    rf_tx_underrun_guard #(.HOLDOFF_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .clear_stats     (clear_stats),
        .i_tdata         (i_tdata),
        .i_tvalid        (i_tvalid),
        .o_tdata         (o_tdata),
        .o_tvalid        (o_tvalid),
        .underrun_count  (underrun_count),
        .underrun_sticky (underrun_sticky),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           en;
        bit           clr;
        bit           vld;
        logic [127:0] data;
        logic [1:0]   exp_st;
        bit           exp_ov;
        bit           exp_pass;  // 1: expect data back, 0: expect zeros
        int           exp_cnt;
        bit           exp_stk;
    } vec_t;

    typedef struct {
        logic [1:0]    st;
        bit            ov;
        logic [127:0]  data;
        logic [CW-1:0] cnt;
        bit            stk;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   seq    = 0;

    function automatic logic [127:0] mk(int k);
        logic [127:0] d;
        for (int s = 0; s < 4; s++) d[s*32 +: 32] = 32'(k * 4 + s);
        return d;
    endfunction

    function automatic void add(bit en, bit clr, bit vld, logic [1:0] st,
                                bit ov, bit pass, int cnt, bit stk);
        vec_t v;
        v.en = en; v.clr = clr; v.vld = vld;
        v.data = mk(seq); seq++;
        v.exp_st = st; v.exp_ov = ov; v.exp_pass = pass;
        v.exp_cnt = cnt; v.exp_stk = stk;
        tbl.push_back(v);
    endfunction

    // HOLD -> 8 discarded valid beats -> RUN. Then one passthrough beat.
    function automatic void add_recover(int cnt, bit stk);
        for (int j = 0; j < HOLD - 1; j++) add(1, 0, 1, 2'd3, 1, 0, cnt, stk);
        add(1, 0, 1, 2'd2, 1, 0, cnt, stk);
        add(1, 0, 1, 2'd2, 1, 1, cnt, stk);
    endfunction

    task automatic check_now(string name, logic [1:0] st, bit ov,
                             logic [127:0] d, logic [CW-1:0] c, bit sk);
        checks++;
        if (state !== st || o_tvalid !== ov || o_tdata !== d ||
            underrun_count !== c || underrun_sticky !== sk) begin
            errors++;
            $display("FAIL %s: got st=%0d v=%0b cnt=%0d stk=%0b data=%h, want st=%0d v=%0b cnt=%0d stk=%0b data=%h",
                     name, state, o_tvalid, underrun_count, underrun_sticky, o_tdata,
                     st, ov, c, sk, d);
        end
    endtask

    initial begin
        vec_t v;
        exp_t e;
        int   c;

        // Reset and idle.
        rst = 1'b1; enable = 1'b0; clear_stats = 1'b0;
        i_tvalid = 1'b1; i_tdata = {4{32'hA5A5A5A5}};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_now($sformatf("reset%0d", i), 2'd0, 0, '0, '0, 0);
        end
        @(negedge clk); rst = 1'b0;

        // Idle after reset release, with valid data present.
        for (int i = 0; i < 3; i++) add(0, 0, 1, 2'd0, 0, 0, 0, 0);
        // Arm: 5 missing-valid beats are zeros and are not underruns.
        for (int i = 0; i < 5; i++) add(1, 0, 0, 2'd1, 1, 0, 0, 0);
        // The first valid beat in ARM passes. Then stream 20 beats in total.
        for (int i = 0; i < 20; i++) add(1, 0, 1, 2'd2, 1, 1, 0, 0);
        // Single underrun: 1 gap beat + 8 discarded = 9 zeros, then passthrough.
        add(1, 0, 0, 2'd3, 1, 0, 1, 1);
        add_recover(1, 1);
        // Interrupted holdoff. Enter HOLD with a coincident clear, so count=1.
        add(1, 1, 0, 2'd3, 1, 0, 1, 1);
        for (int i = 0; i < 5; i++) add(1, 0, 1, 2'd3, 1, 0, 1, 1);
        add(1, 0, 0, 2'd3, 1, 0, 1, 1);
        add_recover(1, 1);
        // Saturation: 20 more events. count = min(1+i, 15).
        for (int i = 1; i <= 20; i++) begin
            c = (1 + i > 15) ? 15 : 1 + i;
            add(1, 0, 0, 2'd3, 1, 0, c, 1);
            add_recover(c, 1);
        end
        // 21st event with a coincident clear: count=1, sticky=1.
        add(1, 1, 0, 2'd3, 1, 0, 1, 1);
        // Dropping enable goes to IDLE and keeps the stats.
        add(0, 0, 1, 2'd0, 0, 0, 1, 1);
        add(1, 0, 1, 2'd1, 1, 0, 1, 1);
        add(1, 0, 1, 2'd2, 1, 1, 1, 1);
        // A clear with no event zeros the stats.
        add(1, 1, 1, 2'd2, 1, 1, 0, 0);
        // Build count=3 in RUN for the async reset test.
        for (int i = 1; i <= 3; i++) begin
            add(1, 0, 0, 2'd3, 1, 0, i, 1);
            add_recover(i, 1);
        end

        foreach (tbl[i]) begin
            v = tbl[i];
            @(negedge clk);
            enable = v.en; clear_stats = v.clr; i_tvalid = v.vld; i_tdata = v.data;
            e.st = v.exp_st; e.ov = v.exp_ov;
            e.data = v.exp_pass ? v.data : '0;
            e.cnt = CW'(v.exp_cnt); e.stk = v.exp_stk;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            check_now($sformatf("vec%0d", i), e.st, e.ov, e.data, e.cnt, e.stk);
        end

        // Async reset between edges while in RUN with count=3.
        checks++;
        if (underrun_count !== CW'(3) || state !== 2'd2) begin
            errors++;
            $display("FAIL pre_rst: got cnt=%0d st=%0d, want cnt=3 st=2",
                     underrun_count, state);
        end
        #2 rst = 1'b1;
        #1 check_now("async_rst", 2'd0, 0, '0, '0, 0);
        @(posedge clk); #1;
        check_now("async_rst_hold", 2'd0, 0, '0, '0, 0);
        @(negedge clk); rst = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        check_now("post_rst", 2'd0, 0, '0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
